// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: rebuilds the scanned hex value and publishes frames.
// Optional build macro SEVEN_SEG_DEC_CHANGE_ONLY_EN: publish only frames that differ from the last.
module seven_seg_scan_decoder #(
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned STABLE_CYC     = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            leds_i,
    input  logic [DIGITS-1:0]     sels_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     dp_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic                  valid_o,
    output logic                  frame_o,
    output logic                  err_o
);

    localparam int unsigned CW = $clog2(STABLE_CYC + 1);
    localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CntMax = CW'(STABLE_CYC);

    // Returns {ok, blank, nibble}; seg is active-high gfedcba.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        unique case (s)
            7'h3F: r = 6'b10_0000;
            7'h06: r = 6'b10_0001;
            7'h5B: r = 6'b10_0010;
            7'h4F: r = 6'b10_0011;
            7'h66: r = 6'b10_0100;
            7'h6D: r = 6'b10_0101;
            7'h7D: r = 6'b10_0110;
            7'h07: r = 6'b10_0111;
            7'h7F: r = 6'b10_1000;
            7'h6F: r = 6'b10_1001;
            7'h77: r = 6'b10_1010;
            7'h7C: r = 6'b10_1011;
            7'h39: r = 6'b10_1100;
            7'h5E: r = 6'b10_1101;
            7'h79: r = 6'b10_1110;
            7'h71: r = 6'b10_1111;
            7'h00: r = 6'b11_0000;
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    // Stage 0 stores the polarity-corrected sample so everything downstream is active-high.
    logic [DIGITS-1:0]   sel_q, prev_sel_q;
    logic [7:0]          seg_q, prev_seg_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] sh_value_q, sh_value_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q, blank_q;
    logic                valid_q, frame_q, err_q, err_d;
    logic                same, cap, pub, pub_fire;
    logic [KW-1:0]       k;
    logic [5:0]          dec;

    assign same = (sel_q == prev_sel_q) && (seg_q == prev_seg_q);
    assign dec  = decode(seg_q[6:0]);
    assign pub  = &seen_q;

`ifdef SEVEN_SEG_DEC_CHANGE_ONLY_EN
    assign pub_fire = pub && (!valid_q ||
                      ({sh_value_q, sh_dp_q, sh_blank_q} != {value_q, dp_q, blank_q}));
`else
    assign pub_fire = pub;
`endif

    always_comb begin
        k = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) k = KW'(i);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        cap   = 1'b0;
        if (sel_q == '0) begin
            cnt_d = '0;
        end else if (!$onehot(sel_q)) begin
            cnt_d = '0;
            err_d = !same;  // one pulse per multi-select episode
        end else begin
            if (!same)                cnt_d = CW'(1);
            else if (cnt_q != CntMax) cnt_d = cnt_q + CW'(1);
            if (cnt_d == CntMax && cnt_q != CntMax) begin
                if (dec[5]) cap   = 1'b1;
                else        err_d = 1'b1;
            end
        end
    end

    always_comb begin
        seen_d     = pub ? '0 : seen_q;
        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        if (cap) begin
            seen_d[k]             = 1'b1;
            sh_value_d[4*k +: 4]  = dec[3:0];
            sh_dp_d[k]            = seg_q[7];
            sh_blank_d[k]         = dec[4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            seg_q      <= '0;
            prev_sel_q <= '0;
            prev_seg_q <= '0;
            cnt_q      <= '0;
            seen_q     <= '0;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            value_q    <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sel_q      <= SEL_ACTIVE_LOW ? ~sels_i : sels_i;
            seg_q      <= SEG_ACTIVE_LOW ? ~leds_i : leds_i;
            prev_sel_q <= sel_q;
            prev_seg_q <= seg_q;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            frame_q    <= pub_fire;
            err_q      <= err_d;
            valid_q    <= valid_q | pub_fire;
            if (pub_fire) begin
                value_q <= sh_value_q;
                dp_q    <= sh_dp_q;
                blank_q <= sh_blank_q;
            end
        end
    end

    assign value_o = value_q;
    assign dp_o    = dp_q;
    assign blank_o = blank_q;
    assign valid_o = valid_q;
    assign frame_o = frame_q;
    assign err_o   = err_q;

endmodule
